// File: rtl/alarm_ctrl_if.sv
// Alarm controller bus: user requests in, LED pattern, buzzer and status flags out.
interface alarm_ctrl_if #(
    parameter int LED_W = 4
);
    logic             alarm;
    logic             stop;
    logic             snooze;
    logic [1:0]       mode;
    logic [LED_W-1:0] led;
    logic             buzzer_out;
    logic             ringing;
    logic             snoozed;
    logic             missed;

    // Side that issues requests and watches the indicators.
    modport master (
        output alarm, stop, snooze, mode,
        input  led, buzzer_out, ringing, snoozed, missed
    );

    // Side implemented by the controller.
    modport slave (
        input  alarm, stop, snooze, mode,
        output led, buzzer_out, ringing, snoozed, missed
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm clock ringer: IDLE / RINGING / SNOOZED state machine driving a gated
// buzzer tone and an LED pattern, with a ring timeout and a bounded snooze count.
module alarm_ctrl #(
    parameter int sys_clk_freq = 100_000_000,
    parameter int LED_W        = 4,
    parameter int TONE_HZ      = 2000,
    parameter int BEEP_MS      = 250,
    parameter int LED_MS       = 1000,
    parameter int TIMEOUT_S    = 60,
    parameter int SNOOZE_S     = 300,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic         clk,
    input  logic         reset_p,
    alarm_ctrl_if.slave  bus
);

    // Period lengths in clock cycles; 64-bit because ring and snooze times
    // exceed 2^32 cycles at realistic clock rates.
    localparam longint HP = longint'(sys_clk_freq) / (2 * TONE_HZ);
    localparam longint BT = (longint'(sys_clk_freq) / 1000) * BEEP_MS;
    localparam longint LT = (longint'(sys_clk_freq) / 1000) * LED_MS;
    localparam longint TT = longint'(sys_clk_freq) * TIMEOUT_S;
    localparam longint ST = longint'(sys_clk_freq) * SNOOZE_S;

    // Each counter runs 0 .. N-1, so it needs clog2(N) bits (at least one).
    localparam int HP_W = (HP > 1) ? $clog2(HP) : 1;
    localparam int BT_W = (BT > 1) ? $clog2(BT) : 1;
    localparam int LT_W = (LT > 1) ? $clog2(LT) : 1;
    localparam int TT_W = (TT > 1) ? $clog2(TT) : 1;
    localparam int ST_W = (ST > 1) ? $clog2(ST) : 1;
    localparam int SC_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

    localparam logic [HP_W-1:0] HP_LAST = HP_W'(HP - 1);
    localparam logic [BT_W-1:0] BT_LAST = BT_W'(BT - 1);
    localparam logic [LT_W-1:0] LT_LAST = LT_W'(LT - 1);
    localparam logic [TT_W-1:0] TT_LAST = TT_W'(TT - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(ST - 1);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } state_t;

    state_t           state;
    logic             alarm_q;
    logic [1:0]       mode_q;
    logic [HP_W-1:0]  tone_cnt;
    logic [BT_W-1:0]  beep_cnt;
    logic [LT_W-1:0]  led_cnt;
    logic [TT_W-1:0]  ring_cnt;
    logic [ST_W-1:0]  snz_cnt;
    logic [SC_W-1:0]  snooze_cnt;
    logic             tone;
    logic             gate;

    logic             tone_wrap;
    logic             beep_wrap;
    logic             led_wrap;
    logic             tone_run;
    logic             gate_run;
    logic [LED_W-1:0] led_step;
    logic [LED_W-1:0] led_run;
    logic             buzz_run;

    // Opening LED pattern of a ring: the chase starts on bit 0, the others dark.
    function automatic logic [LED_W-1:0] led_first(input logic [1:0] m);
        return (m == 2'd1) ? LED_W'(1) : '0;
    endfunction

    // Next tone, beep gate, LED pattern and buzzer level if ringing continues.
    always_comb begin
        // NOTE: led_step gets a default before the case, so no path leaves it
        // unassigned and no latch is inferred.
        led_step = ~bus.led;
        case (mode_q)
            2'd1:    led_step = {bus.led[LED_W-2:0], bus.led[LED_W-1]};
            2'd2:    led_step = (&bus.led) ? '0 : {bus.led[LED_W-2:0], 1'b1};
            default: led_step = ~bus.led;
        endcase
        tone_wrap = (tone_cnt == HP_LAST);
        beep_wrap = (beep_cnt == BT_LAST);
        led_wrap  = (led_cnt == LT_LAST);
        tone_run  = tone ^ tone_wrap;
        gate_run  = gate ^ beep_wrap;
        led_run   = led_wrap ? led_step : bus.led;
        buzz_run  = (mode_q == 2'd1) ? tone_run : (tone_run & gate_run);
    end

    // Ring state machine with its timers and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (reset_p) begin
            state          <= IDLE;
            alarm_q        <= 1'b0;
            mode_q         <= 2'd0;
            tone_cnt       <= '0;
            beep_cnt       <= '0;
            led_cnt        <= '0;
            ring_cnt       <= '0;
            snz_cnt        <= '0;
            snooze_cnt     <= '0;
            tone           <= 1'b0;
            gate           <= 1'b0;
            bus.led        <= '0;
            bus.buzzer_out <= 1'b0;
            bus.ringing    <= 1'b0;
            bus.snoozed    <= 1'b0;
            bus.missed     <= 1'b0;
        end else begin
            alarm_q <= bus.alarm;
            case (state)
                IDLE: begin
                    if (bus.alarm && !alarm_q) begin
                        state          <= RINGING;
                        mode_q         <= bus.mode;
                        tone_cnt       <= '0;
                        beep_cnt       <= '0;
                        led_cnt        <= '0;
                        ring_cnt       <= '0;
                        snooze_cnt     <= '0;
                        tone           <= 1'b0;
                        gate           <= 1'b1;
                        bus.led        <= led_first(bus.mode);
                        bus.buzzer_out <= 1'b0;
                        bus.ringing    <= 1'b1;
                        bus.missed     <= 1'b0;
                    end else if (bus.stop) begin
                        bus.missed <= 1'b0;
                    end
                end

                RINGING: begin
                    if (bus.stop) begin
                        state          <= IDLE;
                        bus.led        <= '0;
                        bus.buzzer_out <= 1'b0;
                        bus.ringing    <= 1'b0;
                    end else if (bus.snooze && (snooze_cnt < SC_MAX)) begin
                        state          <= SNOOZED;
                        snooze_cnt     <= snooze_cnt + 1'b1;
                        snz_cnt        <= '0;
                        bus.led        <= '0;
                        bus.buzzer_out <= 1'b0;
                        bus.ringing    <= 1'b0;
                        bus.snoozed    <= 1'b1;
                    end else if (ring_cnt == TT_LAST) begin
                        state          <= IDLE;
                        bus.led        <= '0;
                        bus.buzzer_out <= 1'b0;
                        bus.ringing    <= 1'b0;
                        bus.missed     <= 1'b1;
                    end else begin
                        ring_cnt       <= ring_cnt + 1'b1;
                        tone_cnt       <= tone_wrap ? '0 : tone_cnt + 1'b1;
                        beep_cnt       <= beep_wrap ? '0 : beep_cnt + 1'b1;
                        led_cnt        <= led_wrap ? '0 : led_cnt + 1'b1;
                        tone           <= tone_run;
                        gate           <= gate_run;
                        bus.led        <= led_run;
                        bus.buzzer_out <= buzz_run;
                    end
                end

                SNOOZED: begin
                    if (bus.stop) begin
                        state       <= IDLE;
                        bus.snoozed <= 1'b0;
                    end else if (snz_cnt == ST_LAST) begin
                        state          <= RINGING;
                        tone_cnt       <= '0;
                        beep_cnt       <= '0;
                        led_cnt        <= '0;
                        ring_cnt       <= '0;
                        tone           <= 1'b0;
                        gate           <= 1'b1;
                        bus.led        <= led_first(mode_q);
                        bus.buzzer_out <= 1'b0;
                        bus.ringing    <= 1'b1;
                        bus.snoozed    <= 1'b0;
                    end else begin
                        snz_cnt <= snz_cnt + 1'b1;
                    end
                end

                default: begin
                    state          <= IDLE;
                    bus.led        <= '0;
                    bus.buzzer_out <= 1'b0;
                    bus.ringing    <= 1'b0;
                    bus.snoozed    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Testbench for alarm_ctrl: per-cycle expectations computed from closed-form
// pattern equations, queued as stimulus is driven and compared after each edge.
module tb_alarm_ctrl;

    localparam int W  = 4;
    localparam int HP = 5;     // 1000 / (2*100)
    localparam int BT = 20;    // 1000/1000*20
    localparam int LT = 40;    // 1000/1000*40

    typedef struct packed {
        logic         ringing;
        logic         snoozed;
        logic         missed;
        logic [W-1:0] led;
        logic         buzzer;
    } obs_t;

    logic clk = 1'b0;
    logic reset_p;
    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    alarm_ctrl_if #(.LED_W(W)) bus ();

    alarm_ctrl #(
        .sys_clk_freq(1000),
        .LED_W       (W),
        .TONE_HZ     (100),
        .BEEP_MS     (20),
        .LED_MS      (40),
        .TIMEOUT_S   (1),
        .SNOOZE_S    (1),
        .MAX_SNOOZE  (2)
    ) dut (
        .clk    (clk),
        .reset_p(reset_p),
        .bus    (bus)
    );

    // Expected outputs k cycles into a ring (k=0 is the cycle after ring start).
    function automatic obs_t ring_exp(input logic [1:0] m, input int k);
        obs_t e;
        int   n;
        logic t;
        logic g;
        e         = '0;
        e.ringing = 1'b1;
        t         = ((k / HP) % 2) == 1;
        g         = ((k / BT) % 2) == 0;
        n         = k / LT;
        case (m)
            2'd1:    e.led = W'(1 << (n % W));
            2'd2:    e.led = W'((1 << (n % (W + 1))) - 1);
            default: e.led = ((n % 2) == 1) ? {W{1'b1}} : '0;
        endcase
        e.buzzer = (m == 2'd1) ? t : (t & g);
        return e;
    endfunction

    function automatic obs_t idle_exp(input logic missed);
        obs_t e;
        e        = '0;
        e.missed = missed;
        return e;
    endfunction

    function automatic obs_t snz_exp();
        obs_t e;
        e         = '0;
        e.snoozed = 1'b1;
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = {bus.ringing, bus.snoozed, bus.missed, bus.led, bus.buzzer_out};
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Give the alarm a clean 0 sample, then raise it; the ring starts on the next edge.
    task automatic arm(input logic [1:0] m);
        bus.mode  = m;
        bus.alarm = 1'b0;
        tick();
        bus.alarm = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got;
        obs_t e;
        reset_p = 1'b1;
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back(idle_exp(1'b0));
            tick();
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset c=%0d got=%b expected=%b", c, got, e);
            end
        end
        reset_p = 1'b0;
    endtask

    // Ring in mode m for n cycles, flip the mode input mid-ring (must stay latched),
    // then stop and confirm a held-high alarm does not retrigger.
    task automatic test_pattern(input logic [1:0] m, input int n);
        obs_t got;
        obs_t e;
        arm(m);
        for (int c = 0; c < n + 2; c++) begin
            bus.stop = (c == n);
            if (c == 10) bus.mode = ~m;
            exp_q.push_back((c < n) ? ring_exp(m, c) : idle_exp(1'b0));
            tick();
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL pattern mode=%0d c=%0d got=%b expected=%b", m, c, got, e);
            end
        end
        bus.stop  = 1'b0;
        bus.alarm = 1'b0;
    endtask

    task automatic test_timeout();
        obs_t got;
        obs_t e;
        arm(2'd0);
        for (int c = 0; c < 1005; c++) begin
            bus.stop = (c == 1003);
            if (c < 1000)      e = ring_exp(2'd0, c);
            else if (c < 1003) e = idle_exp(1'b1);
            else               e = idle_exp(1'b0);
            exp_q.push_back(e);
            tick();
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL timeout c=%0d got=%b expected=%b", c, got, e);
            end
        end
        bus.stop  = 1'b0;
        bus.alarm = 1'b0;
    endtask

    // Two granted snoozes (with an ignored snooze and alarm edge while snoozed),
    // a third snooze refused, then stop and snooze together.
    task automatic test_snooze();
        obs_t got;
        obs_t e;
        arm(2'd2);
        for (int c = 0; c < 2032; c++) begin
            bus.snooze = (c == 5) || (c == 500) || (c == 1012) || (c == 2017) || (c == 2030);
            bus.stop   = (c == 2030);
            bus.alarm  = !((c == 300) || (c == 2020));
            if (c == 3) bus.mode = 2'd1;
            if (c < 5)         e = ring_exp(2'd2, c);
            else if (c < 1005) e = snz_exp();
            else if (c < 1012) e = ring_exp(2'd2, c - 1005);
            else if (c < 2012) e = snz_exp();
            else if (c < 2030) e = ring_exp(2'd2, c - 2012);
            else               e = idle_exp(1'b0);
            exp_q.push_back(e);
            tick();
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL snooze c=%0d got=%b expected=%b", c, got, e);
            end
        end
        bus.snooze = 1'b0;
        bus.stop   = 1'b0;
        bus.alarm  = 1'b0;
    endtask

    // Reset mid-ring with alarm held high: outputs clear, then a fresh ring starts.
    task automatic test_reset_midring();
        obs_t got;
        obs_t e;
        arm(2'd1);
        for (int c = 0; c < 31; c++) begin
            reset_p  = (c == 17) || (c == 18);
            bus.stop = (c == 30);
            if (c < 17)      e = ring_exp(2'd1, c);
            else if (c < 19) e = idle_exp(1'b0);
            else if (c < 30) e = ring_exp(2'd1, c - 19);
            else             e = idle_exp(1'b0);
            exp_q.push_back(e);
            tick();
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL reset_midring c=%0d got=%b expected=%b", c, got, e);
            end
        end
        reset_p   = 1'b0;
        bus.stop  = 1'b0;
        bus.alarm = 1'b0;
    endtask

    initial begin
        reset_p    = 1'b1;
        bus.alarm  = 1'b0;
        bus.stop   = 1'b0;
        bus.snooze = 1'b0;
        bus.mode   = 2'd0;
        test_reset();
        test_pattern(2'd0, 90);
        test_pattern(2'd1, 170);
        test_pattern(2'd2, 210);
        test_pattern(2'd3, 50);
        test_timeout();
        test_snooze();
        test_reset_midring();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter: sys_clk_freq, 100_000_000, clock frequency in Hz.
REQ-002 Parameter: LED_W, 4, LED output width (>=2).
REQ-003 Parameter: TONE_HZ, 2000, buzzer tone frequency; half-period HP = sys_clk_freq/(2*TONE_HZ) cycles.
REQ-004 Parameter: BEEP_MS, 250, beep on/off phase length; BT = sys_clk_freq/1000*BEEP_MS cycles.
REQ-005 Parameter: LED_MS, 1000, LED step period; LT = sys_clk_freq/1000*LED_MS cycles.
REQ-006 Parameter: TIMEOUT_S, 60, max ring time; TT = sys_clk_freq*TIMEOUT_S cycles.
REQ-007 Parameter: SNOOZE_S, 300, snooze length; ST = sys_clk_freq*SNOOZE_S cycles.
REQ-008 Parameter: MAX_SNOOZE, 3, snoozes allowed per alarm event.
REQ-009 Port: clk  input  1  system clock, all logic on rising edge.
REQ-010 Port: reset_p  input  1  reset, synchronous, active-high.
REQ-011 Port: alarm  input  1  alarm request; rising edge triggers.
REQ-012 Port: stop  input  1  one-cycle pulse, dismiss.
REQ-013 Port: snooze  input  1  one-cycle pulse, snooze.
REQ-014 Port: mode  input  2  pattern select, latched at ring start.
REQ-015 Port: led  output  LED_W  LED pattern, registered.
REQ-016 Port: buzzer_out  output  1  gated tone square wave, registered.
REQ-017 Port: ringing / snoozed / missed  output  1 each  status flags, registered.

Function
REQ-018 The block SHALL be an FSM with states IDLE, RINGING, SNOOZED.
REQ-019 IDLE->RINGING SHALL occur on the cycle after alarm is sampled 0 then 1; mode latched; tone, beep, LED, ring timers cleared; snooze count cleared; missed cleared.
REQ-020 In RINGING, stop SHALL go to IDLE next cycle; led, buzzer_out to 0.
REQ-021 In RINGING, snooze with count < MAX_SNOOZE SHALL go to SNOOZED, increment count, clear snooze timer; with count = MAX_SNOOZE snooze SHALL be ignored.
REQ-022 stop and snooze in same cycle: stop SHALL win.
REQ-023 RINGING with ring timer reaching TT-1 SHALL go to IDLE and set missed=1.
REQ-024 In SNOOZED, snooze timer reaching ST-1 SHALL return to RINGING with tone/beep/LED/ring timers cleared, latched mode kept; stop SHALL go to IDLE; snooze ignored.
REQ-025 Alarm rising edges in RINGING or SNOOZED SHALL be ignored; alarm held high SHALL NOT retrigger after return to IDLE.
REQ-026 missed SHALL stay 1 until a stop pulse in IDLE or the next ring start.
REQ-027 ringing=1 exactly in RINGING; snoozed=1 exactly in SNOOZED.
REQ-028 Tone: square wave toggling every HP cycles while RINGING, first toggle to 1 after HP cycles.
REQ-029 Beep gate: starts on, toggles every BT cycles while RINGING.
REQ-030 mode 0: buzzer_out = tone AND gate; all LEDs start 0, invert together every LT cycles.
REQ-031 mode 1: buzzer_out = tone (continuous); LED one-hot chase starting led=1, rotate left every LT cycles, MSB wraps to bit 0.
REQ-032 mode 2: buzzer_out = tone AND gate; LED fills bar 1,3,7,... every LT; all-ones wraps to 0.
REQ-033 mode 3: treated as mode 0.
REQ-034 Outside RINGING, led and buzzer_out SHALL be 0.
REQ-035 Counter widths SHALL hold their max terminal count without overflow.

Reset
REQ-036 reset_p=1 at any cycle SHALL force IDLE, all counters, snooze count and latched mode 0; led=0, buzzer_out=0, ringing=snoozed=missed=0 after that edge.
REQ-037 alarm edge detector SHALL reset its previous-sample register to 0 (alarm high at reset release triggers a ring).

Verification (bench: sys_clk_freq=1000, TONE_HZ=100, BEEP_MS=20, LED_MS=40, TIMEOUT_S=1, SNOOZE_S=1, MAX_SNOOZE=2, LED_W=4)
REQ-038 alarm 0->1, mode=0 -> ringing=1 next cycle; buzzer_out toggles every 5 cycles in first 20, 0 for next 20; led 0000->1111 at cycle 40.
REQ-039 mode=1 ring -> led 0001,0010,0100,1000,0001 at 40-cycle steps; buzzer_out never gated for 40+ cycles.
REQ-040 No stop for 1000 cycles -> IDLE, ringing=0, missed=1; stop pulse -> missed=0.
REQ-041 snooze three times (each after re-ring) -> snoozed=1 for 1000 cycles first two, third ignored; stop+snooze same cycle -> IDLE.
REQ-042 reset_p pulse mid-ring at cycle 17 -> all outputs 0 next cycle; alarm held high -> ringing=1 the cycle after reset_p deasserts.
